// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/multu/div/divu unit for the HI/LO path.
// Optional macro MULDIV_DIV0_FASTPATH_EN: divide by zero completes in one cycle.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  localparam int CW   = $clog2(WIDTH) + 1;
  localparam int MCNT = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

  typedef enum logic [2:0] {
    IDLE, MUL, DIV, FIX, DONE
  } state_t;

  state_t state, nxt;

  logic             op_mul, op_div, op_sgn, op_ok;
  logic             accept, b_zero;
  logic [2*WIDTH-1:0] ea, eb, prod;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] st_r, st_q, st_d;
  logic [2*WIDTH-1:0] st_o;

  logic             mul_q, sgn_q, bsgn_q, div0_q;
  logic [WIDTH-1:0] a_q, rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] div_hi_q, div_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] pipe [MUL_STAGES];
  logic [2*WIDTH-1:0] pipe_last;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             neg_q, neg_r;

  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0] sh;
    logic [WIDTH:0] df;
    logic [2*WIDTH-1:0] res;
    sh = {r, q[WIDTH-1]};
    df = sh - {1'b0, d};
    if (df[WIDTH])
      res = {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    else
      res = {df[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    return res;
  endfunction

  assign op_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div = (op == OP_DIV) || (op == OP_DIVU);
  assign op_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign op_ok  = op_mul || op_div;
  assign b_zero = (b == '0);
  assign accept = start && op_ok && !annul &&
                  (state == IDLE || state == DONE);

  assign ea    = op_sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign eb    = op_sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod  = ea * eb;
  assign a_mag = (op_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op_sgn && b[WIDTH-1]) ? -b : b;

  assign neg_q = sgn_q && (a_q[WIDTH-1] ^ bsgn_q);
  assign neg_r = sgn_q && a_q[WIDTH-1];
  assign pipe_last = pipe[MUL_STAGES-1];

  // Shared divide step: first step runs on the start edge from raw inputs
  always_comb begin
    st_r = '0;
    st_q = a_mag;
    st_d = b_mag;
    if (state == DIV) begin
      st_r = rem_q;
      st_q = quo_q;
      st_d = dvsr_q;
    end
    st_o = div_step(st_r, st_q, st_d);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  // Next-state logic; annul always returns to IDLE
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        nxt = IDLE;
        if (accept) begin
          if (op_mul) begin
            nxt = (MUL_STAGES == 1) ? DONE : MUL;
          end else begin
            nxt = DIV;
`ifdef MULDIV_DIV0_FASTPATH_EN
            if (b_zero) nxt = DONE;
`endif
          end
        end
      end
      MUL: begin
        if (annul)              nxt = IDLE;
        else if (cnt_q == '0)   nxt = DONE;
      end
      DIV: begin
        if (annul)              nxt = IDLE;
        else if (cnt_q == '0)   nxt = FIX;
      end
      FIX: nxt = annul ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs: result is shown live in DONE, held registers otherwise
  always_comb begin
    busy      = (state == MUL) || (state == DIV) || (state == FIX);
    stall_req = busy || (start && op_ok && !annul);
    done      = (state == DONE) && !annul;
    res_hi    = mul_q ? pipe_last[2*WIDTH-1:WIDTH] : div_hi_q;
    res_lo    = mul_q ? pipe_last[WIDTH-1:0] : div_lo_q;
    hi        = done ? res_hi : hi_q;
    lo        = done ? res_lo : lo_q;
    div0      = done && div0_q;
  end

  // Datapath: operand latch, product pipe, divide iterations, sign fixup
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mul_q    <= 1'b0;
      sgn_q    <= 1'b0;
      bsgn_q   <= 1'b0;
      div0_q   <= 1'b0;
      a_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      div_hi_q <= '0;
      div_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else begin
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
      if (accept) begin
        mul_q          <= op_mul;
        sgn_q          <= op_sgn;
        a_q            <= a;
        bsgn_q         <= b[WIDTH-1];
        dvsr_q         <= st_d;
        {rem_q, quo_q} <= st_o;
        div0_q         <= 1'b0;
        cnt_q          <= op_mul ? CW'(MCNT) : CW'(WIDTH - 2);
        if (op_mul) pipe[0] <= prod;
`ifdef MULDIV_DIV0_FASTPATH_EN
        if (op_div && b_zero) begin
          div_hi_q <= a;
          div_lo_q <= '1;
          div0_q   <= 1'b1;
        end
`endif
      end else begin
        case (state)
          MUL: cnt_q <= cnt_q - CW'(1);
          DIV: begin
            {rem_q, quo_q} <= st_o;
            cnt_q          <= cnt_q - CW'(1);
          end
          FIX: begin
            if (dvsr_q == '0) begin
              div_hi_q <= a_q;
              div_lo_q <= '1;
              div0_q   <= 1'b1;
            end else begin
              div_hi_q <= neg_r ? -rem_q : rem_q;
              div_lo_q <= neg_q ? -quo_q : quo_q;
              div0_q   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (done) begin
        hi_q <= hi;
        lo_q <= lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Expected results are queued at issue and checked when done pulses.
module tb_muldiv_unit;

  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

`ifdef MULDIV_DIV0_FASTPATH_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = 33;
`endif

  logic        clk;
  logic        resetn;
  logic        start;
  logic [7:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .a(a), .b(b), .annul(annul), .busy(busy),
    .stall_req(stall_req), .done(done), .hi(hi), .lo(lo),
    .div0(div0)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d0;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every done pulse
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: hi=%h lo=%h cycle %0d",
                 hi, lo, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("div0", 64'(div0), 64'(mon_e.d0));
        chk("done_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic issue(input logic [7:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  task automatic expect_res(input logic [31:0] eh,
                            input logic [31:0] el,
                            input logic ed,
                            input int lat);
    exp_t e;
    e.hi  = eh;
    e.lo  = el;
    e.d0  = ed;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_one(input logic [7:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [31:0] eh,
                         input logic [31:0] el,
                         input logic ed,
                         input int lat);
    issue(o, x, y);
    expect_res(eh, el, ed, lat);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    start  = 1'b0;
    op     = 8'h00;
    a      = '0;
    b      = '0;
    annul  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_stall", 64'(stall_req), 64'h0);
    @(negedge clk);

    run_one(OP_MULT, 32'd3, 32'd5, 32'h0, 32'h0000000F, 1'b0, 2);

    issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
    expect_res(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 2);
    #1 chk("stall_start", 64'(stall_req), 64'h1);
    @(negedge clk);
    start = 1'b0;
    #1 chk("stall_mul", 64'(stall_req), 64'h1);
    chk("busy_mul", 64'(busy), 64'h1);
    @(negedge clk);
    #1 chk("stall_done", 64'(stall_req), 64'h0);
    chk("busy_done", 64'(busy), 64'h0);
    wait_idle();

    run_one(OP_MULTU, 32'hFFFFFFFF, 32'd2,
            32'h00000001, 32'hFFFFFFFE, 1'b0, 2);

    run_one(OP_DIV, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run_one(OP_DIV, 32'h80000000, 32'hFFFFFFFF,
            32'h0, 32'h80000000, 1'b0, 33);
    run_one(OP_DIV, 32'd7, 32'hFFFFFFFE,
            32'd1, 32'hFFFFFFFD, 1'b0, 33);

    issue(OP_DIVU, 32'd100, 32'd7);
    expect_res(32'd2, 32'd14, 1'b0, 33);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL b2b_wait: done=%b required 1", done);
    end
    issue(OP_MULTU, 32'h00010000, 32'h00010000);
    expect_res(32'd1, 32'd0, 1'b0, 2);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    issue(OP_DIV, 32'd100, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    issue(OP_MULT, 32'd2, 32'd2);
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    #1 chk("annul_busy", 64'(busy), 64'h0);
    chk("annul_hi", 64'(hi), 64'h1);
    chk("annul_lo", 64'(lo), 64'h0);
    snap = done_cnt;
    repeat (40) @(negedge clk);
    chk("annul_no_done", 64'(done_cnt), 64'(snap));
    chk("annul_hi_hold", 64'(hi), 64'h1);

    issue(OP_DIVU, 32'd50, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("mrst_hi", 64'(hi), 64'h0);
    chk("mrst_lo", 64'(lo), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    snap = done_cnt;
    repeat (40) @(negedge clk);
    chk("mrst_no_done", 64'(done_cnt), 64'(snap));

    run_one(OP_DIVU, 32'h00001234, 32'h0,
            32'h00001234, 32'hFFFFFFFF, 1'b1, LAT0);
    run_one(OP_DIV, 32'hFFFFFFF0, 32'h0,
            32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, LAT0);

    issue(8'h20, 32'd5, 32'd5);
    #1 chk("bad_op_stall", 64'(stall_req), 64'h0);
    @(negedge clk);
    start = 1'b0;
    #1 chk("bad_op_busy", 64'(busy), 64'h0);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide execution unit for the HI/LO path of the MIPS datapath.
- Sits in the EX stage beside the ALU.
- Accepts the 8-bit ALU operation code produced in decode and executes only the mult, multu, div and divu operations.
- Returns a WIDTH-bit HI/LO pair, and requests a pipeline stall while it is busy.

Parameters:
- WIDTH, 32: operand width; hi and lo are each WIDTH bits; must be even and at least 8.
- MUL_STAGES, 2: multiply latency in cycles, from the start cycle to done; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous active-low reset.
- start  input  1  request in the current cycle.
- op  input  8  operation code from defines.vh: EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP or EXE_DIVU_OP; any other code makes start a no-op.
- a  input  WIDTH  rs operand; the dividend for divide operations.
- b  input  WIDTH  rt operand; the divisor for divide operations.
- annul  input  1  abort the operation in flight (exception or flush).
- busy  output  1  operation in flight.
- stall_req  output  1  combinational; equals busy OR (start AND op is valid AND NOT annul).
- done  output  1  one-cycle pulse; hi and lo are valid in that cycle.
- hi  output  WIDTH  upper product, or the remainder.
- lo  output  WIDTH  lower product, or the quotient.
- div0  output  1  divide-by-zero flag; qualified by done.

Behaviour:
- States:
  - IDLE
  - MUL: pipelined product.
  - DIV: radix-2 restoring division, one quotient bit per cycle.
  - FIX: sign fixup for divide.
  - DONE
- Reset (resetn=0 at an edge): state goes to IDLE; busy, done and div0 are 0; hi and lo are 0; all internal registers are cleared. Reset taken mid-operation discards the operation; no done is produced.
- IDLE:
  - start=1 with a valid op and annul=0 at an edge: latch op, a and b, and move to MUL or DIV.
  - busy=1 from the next cycle.
  - An invalid op or annul=1 leaves the unit in IDLE.
- MUL:
  - Signed or unsigned 2*WIDTH product.
  - done is asserted exactly MUL_STAGES cycles after the start cycle. With MUL_STAGES=1, done is in the cycle immediately after start.
  - {hi,lo} = product.
- DIV, signed (div):
  - Divide the magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - The result is truncated toward zero (MIPS semantics).
  - The most-negative value divided by -1 gives lo = most-negative value and hi = 0, with no trap.
- DIV, unsigned (divu): operands are taken raw.
- DIV timing: WIDTH iteration cycles plus one FIX cycle, so done is asserted WIDTH+1 cycles after the start cycle (33 cycles for WIDTH=32).
- DONE:
  - done=1 for exactly one cycle; hi and lo hold the result.
  - busy drops to 0 in the DONE cycle.
  - The unit returns to IDLE on the next edge.
  - hi and lo hold their value until the next done.
- start is ignored while busy=1. A new start is accepted in the DONE cycle itself (back-to-back). The old result is visible during that cycle.
- annul=1 at any edge while busy, or in the DONE cycle:
  - Next state is IDLE; no done pulse (a pending done is suppressed).
  - hi and lo keep their previous values.
  - annul takes priority over start in the same cycle.
- Divide by zero (b=0):
  - Result is forced to hi=a, lo={WIDTH{1'b1}}, div0=1 in the done cycle, for both div and divu.
  - div0=0 for every other completion.
- The op encodings are 8-bit; compare all 8 bits.

Optional Feature:
- Macro: MULDIV_DIV0_FASTPATH_EN.
- Defined: a divide with b=0 skips DIV/FIX and goes IDLE to DONE, so done is asserted in the cycle after start. The values are the same as above.
- Undefined: a divide by zero takes the full WIDTH+1 cycles, with identical hi, lo and div0 values.
- Multiply behaviour is unaffected in either case.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release. Expect hi=0, lo=0, busy=0, done=0, stall_req=0. Then start with mult 3*5 (MUL_STAGES=2). Expect done two cycles after start, hi=0, lo=0x0000000F.
- Multiply sign handling: a=0xFFFFFFFF, b=2.
  - mult: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - multu: hi=0x00000001, lo=0xFFFFFFFE.
  - stall_req=1 from the start cycle through the cycle before done.
- Signed divide: div a=0xFFFFFFF9 (-7), b=2. Expect done exactly 33 cycles after start, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div a=0x80000000, b=0xFFFFFFFF. Expect lo=0x80000000, hi=0.
- Unsigned divide, back-to-back: divu a=100, b=7 gives lo=14, hi=2. Assert start with multu 0x10000*0x10000 in the done cycle. Expect it accepted, with hi=1, lo=0 two cycles later.
- Divide by zero: divu a=0x1234, b=0. Expect hi=0x1234, lo=0xFFFFFFFF, div0=1. Latency is 1 cycle with MULDIV_DIV0_FASTPATH_EN defined and 33 cycles without it.
- Annul and reset mid-operation:
  - Start div, then annul=1 at cycle 10 with start=1 in the same cycle: no done, busy=0 next cycle, hi and lo unchanged.
  - Start divu, then resetn=0 at cycle 5: hi=0, lo=0, no done.
